// File: rtl/unidade_controle_jogo_pkg.sv
// ----------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the ultimate tic-tac-toe control unit.
//  - STATE_W      : width of the state register and of db_estado
//  - estado_t     : state codes E_INICIAL..E_FIM (code 15 is unused)
//  - controles_t  : bundle of every Moore output driven towards fluxo_dados
// ----------------------------------------------------------------------------
package jogo_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        E_INICIAL      = 4'd0,
        E_PREPARA      = 4'd1,
        E_ESPERA_MACRO = 4'd2,
        E_REG_MACRO    = 4'd3,
        E_VAL_MACRO    = 4'd4,
        E_ESPERA_MICRO = 4'd5,
        E_REG_MICRO    = 4'd6,
        E_VAL_MICRO    = 4'd7,
        E_ESCREVE      = 4'd8,
        E_AGUARDA      = 4'd9,
        E_ESCREVE_EST  = 4'd10,
        E_VERIFICA     = 4'd11,
        E_TROCA        = 4'd12,
        E_VAL_PROX     = 4'd13,
        E_FIM          = 4'd14
    } estado_t;

    // Field order here is the order the outputs are listed for the datapath.
    typedef struct packed {
        logic zeraEdge;
        logic zeraR_micro;
        logic zeraR_macro;
        logic zeraFlipFlopT;
        logic zeraT;
        logic registraR_micro;
        logic registraR_macro;
        logic sinal_macro;
        logic sinal_valida_macro;
        logic we_board;
        logic we_board_state;
        logic troca_jogador;
        logic contaT;
        logic pronto;
    } controles_t;

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// ----------------------------------------------------------------------------
// unidade_controle_jogo_if
// Groups the status lines coming from fluxo_dados and the control lines going
// back to it.
//  master : control unit side (reads status, drives controls and db_estado)
//  slave  : datapath side (drives status, reads controls and db_estado)
// Status  : iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT
// Control : zera*, registraR_*, sinal_*, we_board*, troca_jogador, contaT,
//           pronto, db_estado
// ----------------------------------------------------------------------------
interface unidade_controle_jogo_if;
    import jogo_pkg::*;

    logic               iniciar;
    logic               tem_jogada;
    logic               macro_vencida;
    logic               micro_jogada;
    logic               fim_jogo;
    logic               fimT;

    logic               zeraEdge;
    logic               zeraR_micro;
    logic               zeraR_macro;
    logic               zeraFlipFlopT;
    logic               zeraT;
    logic               registraR_micro;
    logic               registraR_macro;
    logic               sinal_macro;
    logic               sinal_valida_macro;
    logic               we_board;
    logic               we_board_state;
    logic               troca_jogador;
    logic               contaT;
    logic               pronto;
    logic [STATE_W-1:0] db_estado;

    modport master (
        input  iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
        output zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraT,
        output registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
        output we_board, we_board_state, troca_jogador, contaT, pronto, db_estado
    );

    modport slave (
        output iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
        input  zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraT,
        input  registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
        input  we_board, we_board_state, troca_jogador, contaT, pronto, db_estado
    );

endinterface

// File: rtl/unidade_controle_jogo_saidas.sv
// ----------------------------------------------------------------------------
// unidade_controle_saidas
// Pure combinational decoder from the current state to the Moore outputs.
//  estado : current state of the control unit (in)
//  saidas : every control output for that state (out)
// ----------------------------------------------------------------------------
module unidade_controle_saidas
    import jogo_pkg::*;
(
    input  estado_t    estado,
    output controles_t saidas
);

    // Everything defaults to 0, each state then raises only its own lines.
    // INICIAL and any unused code fall through with all outputs low.
    always_comb begin
        saidas = '0;
        case (estado)
            E_PREPARA: begin
                saidas.zeraEdge      = 1'b1;
                saidas.zeraR_micro   = 1'b1;
                saidas.zeraR_macro   = 1'b1;
                saidas.zeraFlipFlopT = 1'b1;
                saidas.zeraT         = 1'b1;
            end
            E_ESPERA_MACRO: begin
                saidas.sinal_macro        = 1'b1;
                saidas.sinal_valida_macro = 1'b1;
            end
            E_REG_MACRO: begin
                saidas.sinal_macro        = 1'b1;
                saidas.registraR_macro    = 1'b1;
                saidas.sinal_valida_macro = 1'b1;
            end
            E_VAL_MACRO: begin
                saidas.sinal_valida_macro = 1'b1;
            end
            E_REG_MICRO: begin
                saidas.registraR_micro = 1'b1;
            end
            E_ESCREVE: begin
                saidas.we_board = 1'b1;
                saidas.zeraT    = 1'b1;
            end
            E_AGUARDA: begin
                saidas.contaT = 1'b1;
            end
            E_ESCREVE_EST: begin
                saidas.we_board_state = 1'b1;
            end
            // sinal_macro stays low so the macro register loads the last
            // micro position: the next play is forced into that macro cell.
            E_TROCA: begin
                saidas.troca_jogador   = 1'b1;
                saidas.registraR_macro = 1'b1;
            end
            E_VAL_PROX: begin
                saidas.sinal_valida_macro = 1'b1;
            end
            E_FIM: begin
                saidas.pronto = 1'b1;
            end
            default: begin
                saidas = '0;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle_jogo.sv
// ----------------------------------------------------------------------------
// unidade_controle_jogo
// Moore control unit sequencing the ultimate tic-tac-toe datapath: reads the
// macro choice, then the micro choice, validates both, writes the board,
// waits for the settle timer, writes the board state, checks for end of game
// and hands the turn to the other player.
//  clock : system clock, all state changes on the rising edge
//  reset : synchronous, active-low; forces INICIAL
//  bus   : master side of unidade_controle_jogo_if (status in, controls out)
// ----------------------------------------------------------------------------
module unidade_controle_jogo
    import jogo_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master bus
);

    estado_t    estado;
    estado_t    proximo;
    controles_t saidas;

    // State register; a low reset wins over any pending transition so an
    // in-flight move is abandoned before any further datapath write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= E_INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic. tem_jogada only matters in the two wait states and
    // iniciar only in INICIAL/FIM, so presses elsewhere are simply dropped.
    // Rejected macro/micro choices go back to their wait state with the same
    // player still on turn.
    always_comb begin
        proximo = estado;
        case (estado)
            E_INICIAL:      if (bus.iniciar)    proximo = E_PREPARA;
            E_PREPARA:                          proximo = E_ESPERA_MACRO;
            E_ESPERA_MACRO: if (bus.tem_jogada) proximo = E_REG_MACRO;
            E_REG_MACRO:                        proximo = E_VAL_MACRO;
            E_VAL_MACRO:    proximo = bus.macro_vencida ? E_ESPERA_MACRO : E_ESPERA_MICRO;
            E_ESPERA_MICRO: if (bus.tem_jogada) proximo = E_REG_MICRO;
            E_REG_MICRO:                        proximo = E_VAL_MICRO;
            E_VAL_MICRO:    proximo = bus.micro_jogada ? E_ESPERA_MICRO : E_ESCREVE;
            E_ESCREVE:                          proximo = E_AGUARDA;
            E_AGUARDA:      if (bus.fimT)       proximo = E_ESCREVE_EST;
            E_ESCREVE_EST:                      proximo = E_VERIFICA;
            E_VERIFICA:     proximo = bus.fim_jogo ? E_FIM : E_TROCA;
            E_TROCA:                            proximo = E_VAL_PROX;
            E_VAL_PROX:     proximo = bus.macro_vencida ? E_ESPERA_MACRO : E_ESPERA_MICRO;
            E_FIM:          if (bus.iniciar)    proximo = E_PREPARA;
            default:                            proximo = E_INICIAL;
        endcase
    end

    unidade_controle_saidas u_saidas (
        .estado (estado),
        .saidas (saidas)
    );

    assign bus.zeraEdge           = saidas.zeraEdge;
    assign bus.zeraR_micro        = saidas.zeraR_micro;
    assign bus.zeraR_macro        = saidas.zeraR_macro;
    assign bus.zeraFlipFlopT      = saidas.zeraFlipFlopT;
    assign bus.zeraT              = saidas.zeraT;
    assign bus.registraR_micro    = saidas.registraR_micro;
    assign bus.registraR_macro    = saidas.registraR_macro;
    assign bus.sinal_macro        = saidas.sinal_macro;
    assign bus.sinal_valida_macro = saidas.sinal_valida_macro;
    assign bus.we_board           = saidas.we_board;
    assign bus.we_board_state     = saidas.we_board_state;
    assign bus.troca_jogador      = saidas.troca_jogador;
    assign bus.contaT             = saidas.contaT;
    assign bus.pronto             = saidas.pronto;
    assign bus.db_estado          = estado;

endmodule
